// File: rtl/dmem_mmio_stage.sv
// dmem_mmio_stage - memory stage of the pipeline.
//   Holds the word-organised data RAM, a memory-mapped LED register and a
//   memory-mapped free-running timer. Performs byte/half/word store lane
//   selection, load sign/zero extension and tracks misaligned accesses.
//
// Build option: define MISALIGN_TRAP_EN to detect, suppress and flag misaligned
//   half/word accesses. Without it, half/word addresses are force-aligned and
//   the misaligned flag stays 0.
//
// Ports:
//   clk          in   clock, all state updates on rising edge
//   reset        in   synchronous, active-high
//   MemWriteM    in   store strobe
//   MemReadM     in   load qualifier (only used for misalignment detection)
//   ALUResultM   in   [31:0] byte address
//   WriteDataM   in   [31:0] right-aligned store data
//   DextControlM in   [2:0]  funct3 of the access
//   ReadDataM    out  [31:0] extended load data, combinational
//   ledON        out  LED register equals LED_MATCH
//   misaligned   out  sticky misaligned-access flag
//   timer_q      out  [31:0] current timer value
module dmem_mmio_stage #(
    parameter int          DEPTH_WORDS = 64,
    parameter logic [31:0] LED_ADDR    = 32'd100,
    parameter logic [31:0] TIMER_ADDR  = 32'd104,
    parameter logic [31:0] LED_MATCH   = 32'd25
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWriteM,
    input  logic        MemReadM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [2:0]  DextControlM,
    output logic [31:0] ReadDataM,
    output logic        ledON,
    output logic        misaligned,
    output logic [31:0] timer_q
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH_WORDS);

    // Lane enables for a store of the given width at the given byte offset.
    function automatic logic [3:0] lane_en(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            2'b00:   lane_en = 4'b0001 << off;
            2'b01:   lane_en = off[1] ? 4'b1100 : 4'b0011;
            default: lane_en = 4'b1111;
        endcase
    endfunction

    // Replicate the low byte/half across the word so any enabled lane sees it.
    function automatic logic [31:0] store_data(input logic [1:0] sz, input logic [31:0] wd);
        case (sz)
            2'b00:   store_data = {4{wd[7:0]}};
            2'b01:   store_data = {2{wd[15:0]}};
            default: store_data = wd;
        endcase
    endfunction

    // Pick the addressed byte/half out of a RAM word and extend it.
    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] f3,
                                                input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  load_extend = {{24{b[7]}}, b};
            3'b100:  load_extend = {24'h000000, b};
            3'b001:  load_extend = {{16{h[15]}}, h};
            3'b101:  load_extend = {16'h0000, h};
            default: load_extend = word;
        endcase
    endfunction

    logic [31:0]   ram [DEPTH_WORDS];
    logic [31:0]   led_q, led_d, timer_d;
    logic          ledon_q, ledon_d, misaligned_q, misaligned_d;
    logic          is_half_s, is_word_s, mis_s, store_ok_s;
    logic          led_hit_s, timer_hit_s, ram_hit_s;
    logic [31:0]   eff_addr_s;
    logic [AW-1:0] ram_idx_s;
    logic [3:0]    lane_en_s;
    logic [31:0]   wdata_s;

    assign is_half_s = (DextControlM[1:0] == 2'b01);
    assign is_word_s = DextControlM[1];

`ifdef MISALIGN_TRAP_EN
    assign mis_s      = (MemWriteM | MemReadM) &
                        ((is_half_s & ALUResultM[0]) | (is_word_s & (ALUResultM[1:0] != 2'b00)));
    assign eff_addr_s = ALUResultM;
`else
    logic unused_s;
    assign unused_s   = MemReadM;
    assign mis_s      = 1'b0;
    // Half/word accesses drop their low address bits and hit the aligned location.
    assign eff_addr_s = is_word_s ? {ALUResultM[31:2], 2'b00} :
                        is_half_s ? {ALUResultM[31:1], 1'b0}  : ALUResultM;
`endif

    // MMIO addresses win over the RAM range they overlap.
    assign led_hit_s   = (eff_addr_s == LED_ADDR);
    assign timer_hit_s = ~led_hit_s & (eff_addr_s == TIMER_ADDR);
    assign ram_hit_s   = ~led_hit_s & ~timer_hit_s & (eff_addr_s < RAM_BYTES);
    assign ram_idx_s   = eff_addr_s[AW+1:2];
    assign store_ok_s  = MemWriteM & ~mis_s;
    assign lane_en_s   = lane_en(DextControlM[1:0], eff_addr_s[1:0]);
    assign wdata_s     = store_data(DextControlM[1:0], WriteDataM);

    // Combinational load path; MMIO always returns the full register.
    always_comb begin
        ReadDataM = 32'h0000_0000;
        if (mis_s) begin
            ReadDataM = 32'h0000_0000;
        end else if (led_hit_s) begin
            ReadDataM = led_q;
        end else if (timer_hit_s) begin
            ReadDataM = timer_q;
        end else if (ram_hit_s) begin
            ReadDataM = load_extend(ram[ram_idx_s], DextControlM, eff_addr_s[1:0]);
        end else begin
            ReadDataM = 32'h0000_0000;
        end
    end

    // Next-state for LED, timer and flags; MMIO registers accept only SW.
    always_comb begin
        led_d   = led_q;
        timer_d = timer_q + 32'd1;
        if (store_ok_s & is_word_s & led_hit_s) begin
            led_d = WriteDataM;
        end else begin
            led_d = led_q;
        end
        if (store_ok_s & is_word_s & timer_hit_s) begin
            timer_d = WriteDataM;
        end else begin
            timer_d = timer_q + 32'd1;
        end
        ledon_d      = (led_d == LED_MATCH);
        misaligned_d = misaligned_q | mis_s;
    end

    // MMIO and flag registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            led_q        <= 32'h0000_0000;
            timer_q      <= 32'h0000_0000;
            ledon_q      <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            led_q        <= led_d;
            timer_q      <= timer_d;
            ledon_q      <= ledon_d;
            misaligned_q <= misaligned_d;
        end
    end

    // RAM byte-lane writes; RAM is not reset, so a store during reset still lands.
    always_ff @(posedge clk) begin
        if (store_ok_s & ram_hit_s) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en_s[i]) begin
                    ram[ram_idx_s][8*i +: 8] <= wdata_s[8*i +: 8];
                end
            end
        end
    end

    assign ledON      = ledon_q;
    assign misaligned = misaligned_q;

endmodule

// File: tb/tb_dmem_mmio_stage.sv
module tb_dmem_mmio_stage;

`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, MemWriteM, MemReadM;
    logic [31:0] ALUResultM, WriteDataM;
    logic [2:0]  DextControlM;
    logic [31:0] ReadDataM, timer_q;
    logic        ledON, misaligned;

    always #5 clk = ~clk;

    dmem_mmio_stage dut (
        .clk(clk), .reset(reset), .MemWriteM(MemWriteM), .MemReadM(MemReadM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .DextControlM(DextControlM),
        .ReadDataM(ReadDataM), .ledON(ledON), .misaligned(misaligned), .timer_q(timer_q)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: byte-addressed memory plus two MMIO registers.
    logic [7:0]  mem_m [256];
    logic [31:0] led_m, timer_m;
    logic        mis_m;
    logic        model_valid = 1'b0;

    function automatic int sz(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] addr, input logic [2:0] f3);
        int s;
        logic [31:0] a, v;
        s = sz(f3);
        if (TRAP && (addr % 32'(s)) != 32'd0) return 32'd0;
        a = addr - (addr % 32'(s));
        if (a == 32'd100) return led_m;
        if (a == 32'd104) return timer_m;
        if (a >= 32'd256) return 32'd0;
        v = 32'd0;
        for (int i = 0; i < s; i++) v = v | (32'(mem_m[int'(a) + i]) << (8 * i));
        if (!f3[2] && s == 1 && v[7])  v = v | 32'hFFFF_FF00;
        if (!f3[2] && s == 2 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    int          m_size;
    logic [31:0] m_eff;
    logic        m_mis;
    always_comb begin
        m_size = sz(DextControlM);
        m_eff  = TRAP ? ALUResultM : ALUResultM - (ALUResultM % 32'(m_size));
        m_mis  = TRAP && (MemWriteM || MemReadM) && ((ALUResultM % 32'(m_size)) != 32'd0);
    end

    // Model update at each rising edge.
    always @(posedge clk) begin
        if (MemWriteM && !m_mis && m_eff < 32'd256 && m_eff != 32'd100 && m_eff != 32'd104)
            for (int i = 0; i < m_size; i++) mem_m[int'(m_eff) + i] <= WriteDataM[8*i +: 8];
        if (reset) begin
            led_m       <= 32'd0;
            timer_m     <= 32'd0;
            mis_m       <= 1'b0;
            model_valid <= 1'b1;
        end else begin
            if (MemWriteM && !m_mis && m_size == 4 && m_eff == 32'd104) timer_m <= WriteDataM;
            else timer_m <= timer_m + 32'd1;
            if (MemWriteM && !m_mis && m_size == 4 && m_eff == 32'd100) led_m <= WriteDataM;
            if (m_mis) mis_m <= 1'b1;
        end
    end

    // Compare process: every cycle once the model has seen a reset.
    always @(negedge clk) begin
        if (model_valid) begin
            chk("timer", timer_q, timer_m);
            chk("ledON", 32'(ledON), 32'(led_m == 32'd25));
            chk("misaligned", 32'(misaligned), 32'(mis_m));
            if (MemReadM) chk("rdata", ReadDataM, model_read(ALUResultM, DextControlM));
        end
    end

    task automatic cyc(input logic r, input logic we, input logic re, input logic [31:0] a,
                       input logic [31:0] wd, input logic [2:0] f3);
        reset = r; MemWriteM = we; MemReadM = re; ALUResultM = a; WriteDataM = wd; DextControlM = f3;
        @(posedge clk);
        #1;
    endtask

    task automatic ldchk(input string name, input logic [31:0] a, input logic [2:0] f3,
                         input logic [31:0] exp);
        reset = 1'b0; MemWriteM = 1'b0; MemReadM = 1'b1; ALUResultM = a; WriteDataM = 32'd0;
        DextControlM = f3;
        #2;
        chk(name, ReadDataM, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] a, wd;
        logic [2:0]  f3;
        logic        r, we, re;
        int          sel, op;

        cyc(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 3'b010);
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 3'b010);
        chk("rst_timer", timer_q, 32'd0);
        chk("rst_led", 32'(ledON), 32'd0);
        chk("rst_mis", 32'(misaligned), 32'd0);

        // Give every reachable RAM byte a known value.
        for (int w = 0; w < 64; w++) cyc(1'b0, 1'b1, 1'b0, 32'(4 * w), 32'd0, 3'b010);
        for (int b = 101; b < 108; b++)
            if (b != 104) cyc(1'b0, 1'b1, 1'b0, 32'(b), 32'd0, 3'b000);

        // Byte loads with extension.
        cyc(1'b0, 1'b1, 1'b0, 32'd8, 32'h8001_7F10, 3'b010);
        ldchk("lb8", 32'd8, 3'b000, 32'h0000_0010);
        ldchk("lb9", 32'd9, 3'b000, 32'h0000_007F);
        ldchk("lbu11", 32'd11, 3'b100, 32'h0000_0080);
        ldchk("lb11", 32'd11, 3'b000, 32'hFFFF_FF80);

        // Sub-word stores preserve other lanes.
        cyc(1'b0, 1'b1, 1'b0, 32'd12, 32'hAAAA_AAAA, 3'b010);
        cyc(1'b0, 1'b1, 1'b0, 32'd13, 32'h0000_0055, 3'b000);
        cyc(1'b0, 1'b1, 1'b0, 32'd14, 32'h0000_1234, 3'b001);
        ldchk("lw12", 32'd12, 3'b010, 32'h1234_55AA);
        ldchk("lh14", 32'd14, 3'b001, 32'h0000_1234);

        // LED register.
        cyc(1'b0, 1'b1, 1'b0, 32'd100, 32'd25, 3'b010);
        chk("led_sw25", 32'(ledON), 32'd1);
        cyc(1'b0, 1'b1, 1'b0, 32'd100, 32'd24, 3'b010);
        chk("led_sw24", 32'(ledON), 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 32'd100, 32'd25, 3'b000);
        chk("led_sb25", 32'(ledON), 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 32'd100, 32'd25, 3'b010);
        cyc(1'b0, 1'b1, 1'b0, 32'd100, 32'd7, 3'b001);
        chk("led_sh7", 32'(ledON), 32'd1);
        ldchk("lw100", 32'd100, 3'b000, 32'd25);

        // Timer load and wrap.
        cyc(1'b0, 1'b1, 1'b0, 32'd104, 32'hFFFF_FFFE, 3'b010);
        chk("tmr_load", timer_q, 32'hFFFF_FFFE);
        ldchk("lw104", 32'd104, 3'b010, 32'hFFFF_FFFE);
        chk("tmr_ff", timer_q, 32'hFFFF_FFFF);
        cyc(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'b010);
        chk("tmr_wrap", timer_q, 32'h0000_0000);

        // Misaligned word store.
        cyc(1'b0, 1'b1, 1'b0, 32'd18, 32'h1111_1111, 3'b010);
        chk("mis_flag", 32'(misaligned), TRAP ? 32'd1 : 32'd0);
        ldchk("lw16", 32'd16, 3'b010, TRAP ? 32'd0 : 32'h1111_1111);
        chk("mis_sticky", 32'(misaligned), TRAP ? 32'd1 : 32'd0);

        // Unmapped store is dropped and does not alias onto word 0.
        cyc(1'b0, 1'b1, 1'b0, 32'd256, 32'hDEAD_BEEF, 3'b010);
        ldchk("lw256", 32'd256, 3'b010, 32'd0);
        ldchk("lw0", 32'd0, 3'b010, 32'd0);

        // Reset overrides a same-cycle MMIO store.
        cyc(1'b0, 1'b1, 1'b0, 32'd100, 32'd25, 3'b010);
        chk("led_pre_rst", 32'(ledON), 32'd1);
        cyc(1'b1, 1'b1, 1'b0, 32'd100, 32'd25, 3'b010);
        chk("rst_store_led", 32'(ledON), 32'd0);
        chk("rst_store_tmr", timer_q, 32'd0);

        // Randomized traffic checked by the model.
        for (int n = 0; n < 3000; n++) begin
            r   = ($urandom_range(0, 199) == 0);
            op  = $urandom_range(0, 2);
            we  = (op == 1);
            re  = (op == 2);
            sel = $urandom_range(0, 11);
            case (sel)
                0:       a = 32'd100 + 32'($urandom_range(0, 3));
                1:       a = 32'd104 + 32'($urandom_range(0, 3));
                2:       a = 32'd256 + 32'($urandom_range(0, 15));
                3:       a = 32'd252 + 32'($urandom_range(0, 7));
                4:       a = $urandom();
                default: a = 32'($urandom_range(0, 255));
            endcase
            wd = ($urandom_range(0, 3) == 0) ? 32'd25 : $urandom();
            f3 = 3'($urandom_range(0, 7));
            cyc(r, we, re, a, wd, f3);
        end
        cyc(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'b010);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_mmio_stage.md
Name: dmem_mmio_stage

Overview:
- Memory-stage consumer of the pipeline's M-stage outputs (MemWriteM, ALUResultM, WriteDataM, DextControlM).
- Returns ReadDataM combinationally in the same cycle.
- Holds the word-organised data RAM, a memory-mapped LED register and a memory-mapped free-running timer.
- Applies byte/half/word store lane selection, load sign/zero extension, and tracks misaligned accesses.

Parameters:
DEPTH_WORDS, 64, number of 32-bit RAM words; RAM byte range is 0 .. 4*DEPTH_WORDS-1
LED_ADDR, 32'd100, word address of the LED register
TIMER_ADDR, 32'd104, word address of the timer register
LED_MATCH, 32'd25, LED register value that lights ledON

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high
MemWriteM  input  1  store strobe for the current M-stage instruction
MemReadM  input  1  load qualifier; gates misaligned detection only
ALUResultM  input  32  byte address
WriteDataM  input  32  store data, right-aligned
DextControlM  input  3  funct3 of the access
ReadDataM  output  32  extended load data, combinational
ledON  output  1  LED register equals LED_MATCH
misaligned  output  1  sticky misaligned-access flag
timer_q  output  32  current timer value

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values:
  - LED register = 0, so ledON = 0.
  - Timer = 0, misaligned = 0.
  - RAM contents are not reset; simulation initialises RAM to 0.
- Address decode, in priority order:
  - addr == LED_ADDR -> LED register.
  - addr == TIMER_ADDR -> timer.
  - addr < 4*DEPTH_WORDS -> RAM word addr[log2(DEPTH_WORDS)+1:2].
  - Otherwise unmapped: stores are dropped, loads return 0.
  - MMIO addresses take priority over an overlapping RAM range.
- Store width, from DextControlM[1:0]:
  - 00 SB: writes the byte lane addr[1:0].
  - 01 SH: writes lanes {addr[1],0} and {addr[1],1}.
  - 10/11 SW: writes all lanes.
  - WriteDataM low byte/half is replicated into the selected lane(s); unselected lanes are preserved.
- MMIO stores: accepted only as SW; SB/SH to an MMIO address are dropped.
- Load decode from DextControlM:
  - 000 LB: sign-extend the byte at lane addr[1:0].
  - 100 LBU: zero-extend the byte at lane addr[1:0].
  - 001 LH: sign-extend the half at addr[1].
  - 101 LHU: zero-extend the half at addr[1].
  - 010 and reserved codes 011/110/111: full word.
  - MMIO reads always return the full 32-bit register, regardless of DextControlM.
- Read timing: ReadDataM is purely combinational from current state. A store at cycle N is visible to a load at cycle N+1. No simultaneous load/store to the same address occurs by construction.
- Timer:
  - Increments by 1 every cycle; wraps 0xFFFF_FFFF -> 0.
  - An SW to TIMER_ADDR in cycle N loads WriteDataM, overriding that cycle's increment; timer_q = WriteDataM at N+1, then counts on.
- LED: ledON = (LED register == LED_MATCH), registered value only; it is not combinational on the write bus.
- Misalignment:
  - A halfword access is misaligned when addr[0]=1.
  - A word access is misaligned when addr[1:0] != 0.
  - Qualified by MemWriteM or MemReadM.
  - A misaligned store is suppressed; no RAM or MMIO change.
  - A misaligned load returns 0.
  - misaligned is set the cycle after detection and holds until reset.
- Reset asserted mid-sequence: it overrides a same-cycle store to MMIO, and the timer goes to 0. A same-cycle RAM store is still performed, since RAM is not reset.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: misalignment detection, suppression and the sticky flag operate as described above.
- Undefined:
  - No detection; misaligned is tied 0.
  - Halfword accesses ignore addr[0]; word accesses ignore addr[1:0] (force-aligned).
  - The access proceeds normally on the aligned location.

Test Plan:
- Reset, then SW 0x8001_7F10 to addr 8; LB addr 8 -> 0x0000_0010; LB addr 9 -> 0x0000_007F; LBU addr 11 -> 0x0000_0080; LB addr 11 -> 0xFFFF_FF80.
- SW 0xAAAA_AAAA to addr 12, then SB 0x55 to addr 13 and SH 0x1234 to addr 14; LW addr 12 -> 0x1234_55AA; LH addr 14 -> 0x0000_1234.
- SW 25 to addr 100 -> ledON = 1 next cycle; SW 24 to addr 100 -> ledON = 0 next cycle; SB 25 to addr 100 -> ledON unchanged.
- SW 0xFFFF_FFFE to addr 104 -> timer_q = 0xFFFF_FFFE, then 0xFFFF_FFFF, then 0x0000_0000 on successive cycles; LW addr 104 returns timer_q.
- With MISALIGN_TRAP_EN: SW 0x1111_1111 to addr 18 -> RAM word 4 unchanged, misaligned = 1 next cycle and stays 1 until reset. Without the macro: same store writes word 4 = 0x1111_1111 and misaligned stays 0.
- SW 0xDEAD_BEEF to addr 4*DEPTH_WORDS (256) -> dropped; LW addr 256 -> 0. Reset asserted in the same cycle as SW 25 to addr 100 -> ledON = 0 and timer_q = 0 after the edge.
